// File: rtl/lab3_serial_pattern_detector_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding
// and the default pattern parameters.
package lab3_serial_pattern_detector_pkg;

  // Detector FSM states; encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HUNT = 2'd2
  } state_e;

  localparam int         DEF_PATTERN_W = 4;
  localparam logic [3:0] DEF_PATTERN   = 4'b1011;

endpackage

// File: rtl/lab3_sat_counter.sv
// Saturating up-counter with synchronous clear and a registered
// "all ones" flag that tracks the count value in the same cycle.
module lab3_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  // Next count: clear wins over increment; the flag is derived from the
  // next count so it lands in the same cycle as the count itself.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = sat_inc(count_q);
    end
    sat_d = &count_d;
  end

  // Count and saturation flag registers.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/lab3_serial_pattern_detector.sv
// Serial pattern detector: shifts the registered serial bit into a
// PATTERN_W-bit window while enabled, pulses match when the window holds
// PATTERN, and counts matches in a saturating counter.
module lab3_serial_pattern_detector
  import lab3_serial_pattern_detector_pkg::*;
#(
  parameter int                   PATTERN_W = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(DEF_PATTERN),
  parameter int                   OVERLAP   = 1,
  parameter int                   CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             enable,
  input  logic             clear,
  input  logic             din,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat,
  output logic [1:0]       state
);

  // fill counts valid bits in the window, 0..PATTERN_W inclusive.
  localparam int                FILL_W    = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

  logic [PATTERN_W-1:0] window_q, window_d, nw;
  logic [FILL_W-1:0]    fill_q, fill_d, nf;
  logic                 match_q, match_d;
  logic                 hit;
  logic                 cnt_inc;
  state_e               state_q, state_d;

  // Candidate window/fill after sampling din; a hit needs a full window.
  always_comb begin
    nw  = {window_q[PATTERN_W-2:0], din};
    nf  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    hit = (nf == FILL_FULL) && (nw == PATTERN);
  end

  // Next-state logic. The next FSM state depends only on clear/enable and
  // the next fill, so an illegal encoding falls back to IDLE on its own.
  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    match_d  = 1'b0;
    state_d  = ST_IDLE;
    if (clear) begin
      window_d = '0;
      fill_d   = '0;
    end else if (enable) begin
      window_d = nw;
      match_d  = hit;
      // Without overlap a completed match discards the window's bits.
      fill_d   = (hit && (OVERLAP == 0)) ? '0 : nf;
      state_d  = (nf == FILL_FULL) ? ST_HUNT : ST_FILL;
    end
  end

  // Window, fill, match pulse and FSM state registers.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      window_q <= '0;
      fill_q   <= '0;
      match_q  <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      state_q  <= state_d;
    end
  end

  assign cnt_inc = enable & ~clear & hit;

  lab3_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock   (clock),
    .reset_b (reset_b),
    .inc     (cnt_inc),
    .clr     (clear),
    .count   (match_count),
    .sat     (count_sat)
  );

  assign match = match_q;
  assign state = state_q;

endmodule

// File: tb/tb_lab3_serial_pattern_detector.sv
// Bench for the serial pattern detector. Three instances share one input
// stream: overlapping (u_ov), non-overlapping (u_nov) and non-overlapping
// with a 2-bit counter (u_sat). A history-based model predicts all outputs.
module tb_lab3_serial_pattern_detector;

  logic clock;
  logic reset_b;
  logic enable;
  logic clear;
  logic din;

  logic       m_ov,  m_nov,  m_sat;
  logic [7:0] c_ov,  c_nov;
  logic [1:0] c_sat;
  logic       s_ov,  s_nov,  s_sat;
  logic [1:0] st_ov, st_nov, st_sat;

  int n_checks = 0;
  int n_fail   = 0;

  lab3_serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) u_ov (
    .clock(clock), .reset_b(reset_b), .enable(enable), .clear(clear), .din(din),
    .match(m_ov), .match_count(c_ov), .count_sat(s_ov), .state(st_ov));

  lab3_serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) u_nov (
    .clock(clock), .reset_b(reset_b), .enable(enable), .clear(clear), .din(din),
    .match(m_nov), .match_count(c_nov), .count_sat(s_nov), .state(st_nov));

  lab3_serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(2)) u_sat (
    .clock(clock), .reset_b(reset_b), .enable(enable), .clear(clear), .din(din),
    .match(m_sat), .match_count(c_sat), .count_sat(s_sat), .state(st_sat));

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: number of bits sampled since the last restart and the
  // recent history of sampled bits; a match is "at least 4 fresh bits and
  // the newest four read 1011".
  int          md_n    [3];
  logic [15:0] md_h    [3];
  int          md_hits [3];
  bit          md_match[3];
  int          md_state[3];

  always @(posedge clock or negedge reset_b) begin : model
    for (int i = 0; i < 3; i++) begin
      if (!reset_b || clear) begin
        md_n[i]     <= 0;
        md_h[i]     <= '0;
        md_hits[i]  <= 0;
        md_match[i] <= 1'b0;
        md_state[i] <= 0;
      end else if (!enable) begin
        md_match[i] <= 1'b0;
        md_state[i] <= 0;
      end else begin : smp
        logic [15:0] h;
        int          n;
        bit          hit;
        h   = {md_h[i][14:0], din};
        n   = md_n[i] + 1;
        hit = (n >= 4) && (h[3:0] == 4'b1011);
        md_h[i]     <= h;
        md_match[i] <= hit;
        md_state[i] <= (n >= 4) ? 2 : 1;
        md_hits[i]  <= md_hits[i] + (hit ? 1 : 0);
        md_n[i]     <= (hit && i != 0) ? 0 : n;
      end
    end
  end

  function automatic int exp_cnt(input int i);
    int maxc;
    maxc = (i == 2) ? 3 : 255;
    return (md_hits[i] > maxc) ? maxc : md_hits[i];
  endfunction

  function automatic int exp_sat(input int i);
    return (exp_cnt(i) == ((i == 2) ? 3 : 255)) ? 1 : 0;
  endfunction

  // Every-cycle comparison, on the falling edge.
  always @(negedge clock) begin
    chk("ov.match",  int'(m_ov),   int'(md_match[0]));
    chk("ov.count",  int'(c_ov),   exp_cnt(0));
    chk("ov.sat",    int'(s_ov),   exp_sat(0));
    chk("ov.state",  int'(st_ov),  md_state[0]);
    chk("nov.match", int'(m_nov),  int'(md_match[1]));
    chk("nov.count", int'(c_nov),  exp_cnt(1));
    chk("nov.sat",   int'(s_nov),  exp_sat(1));
    chk("nov.state", int'(st_nov), md_state[1]);
    chk("sat.match", int'(m_sat),  int'(md_match[2]));
    chk("sat.count", int'(c_sat),  exp_cnt(2));
    chk("sat.sat",   int'(s_sat),  exp_sat(2));
    chk("sat.state", int'(st_sat), md_state[2]);
  end

  // Drive one cycle of inputs 5 ns after an edge, return 5 ns after the next edge.
  task automatic cyc(input logic b, input logic en, input logic cl);
    din    = b;
    enable = en;
    clear  = cl;
    @(posedge clock);
    #5;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin : stim
    logic [6:0] s1;
    reset_b = 1'b0;
    enable  = 1'b0;
    clear   = 1'b0;
    din     = 1'b0;
    repeat (2) @(posedge clock);
    #5;
    reset_b = 1'b1;
    chk("reset.match", int'(m_ov), 0);
    chk("reset.count", int'(c_ov), 0);
    chk("reset.state", int'(st_ov), 0);

    // Overlap vs non-overlap on 1,0,1,1,0,1,1 (oldest first).
    cyc(1'b0, 1'b0, 1'b1);
    s1 = 7'b1011011;
    for (int k = 6; k >= 0; k--) begin
      cyc(s1[k], 1'b1, 1'b0);
      if (k == 3) begin
        chk("t1.ov.match4",  int'(m_ov),  1);
        chk("t2.nov.match4", int'(m_nov), 1);
        chk("t1.ov.state4",  int'(st_ov), 2);
      end
      if (k == 2) chk("t1.ov.match5", int'(m_ov), 0);
    end
    chk("t1.ov.match7",  int'(m_ov),  1);
    chk("t1.ov.count",   int'(c_ov),  2);
    chk("t2.nov.match7", int'(m_nov), 0);
    chk("t2.nov.count",  int'(c_nov), 1);

    // Enable gap in the middle of a pattern.
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t3.state.fill", int'(st_ov), 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk("t3.gap.match", int'(m_ov), 0);
      chk("t3.gap.state", int'(st_ov), 0);
    end
    cyc(1'b1, 1'b1, 1'b0);
    chk("t3.match3", int'(m_ov), 0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t3.match4", int'(m_ov), 1);
    chk("t3.count",  int'(c_ov), 1);

    // Asynchronous reset after 1,0,1 discards the partial window.
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t4.pre.count", int'(c_ov), 1);
    enable = 1'b0;
    @(posedge clock);
    #3;
    reset_b = 1'b0;
    #1;
    chk("t4.async.count", int'(c_ov),  0);
    chk("t4.async.match", int'(m_ov),  0);
    chk("t4.async.state", int'(st_ov), 0);
    chk("t4.async.sat",   int'(s_sat), 0);
    @(posedge clock);
    #5;
    reset_b = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    chk("t4.after1.match", int'(m_ov), 0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t4.after3.match", int'(m_ov), 0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t4.after4.match", int'(m_ov), 1);
    chk("t4.after4.count", int'(c_ov), 1);

    // Saturation of the 2-bit counter over five matches.
    cyc(1'b0, 1'b0, 1'b1);
    for (int m = 1; m <= 5; m++) begin
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("t5.match", int'(m_sat), 1);
      chk("t5.count", int'(c_sat), (m > 3) ? 3 : m);
      chk("t5.sat",   int'(s_sat), (m >= 3) ? 1 : 0);
    end
    chk("t5.nov.count", int'(c_nov), 5);

    // Clear together with enable on the final pattern bit.
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("t6.match", int'(m_ov),  0);
    chk("t6.count", int'(c_ov),  0);
    chk("t6.state", int'(st_ov), 0);
    chk("t6.sat",   int'(s_sat), 0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t6.fresh.match", int'(m_ov), 0);
    chk("t6.fresh.state", int'(st_ov), 1);

    cyc(1'b0, 1'b0, 1'b0);
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
